// File: rtl/bomb_scheduler.sv
// Bomb slot scheduler: shared pool of bomb slots for both avatars.
// Arbitrates placement requests, runs per-slot fuse/flame timers,
// propagates chain reactions and publishes bomb, flame and tree-clear maps.
module bomb_scheduler #(
    parameter int unsigned SLOTS          = 4,
    parameter int unsigned MAX_PER_PLAYER = 2,
    parameter int unsigned FUSE_FRAMES    = 120,
    parameter int unsigned FLAME_FRAMES   = 30,
    parameter int unsigned GRID_W         = 12
) (
    input  logic                       Frame_Clk,
    input  logic                       Reset,
    input  logic [31:0]                Bomb_Req_1,
    input  logic [31:0]                Bomb_Req_2,
    input  logic [GRID_W*GRID_W-1:0]   Wall_Map,
    input  logic [GRID_W*GRID_W-1:0]   Tree_Map,
    output logic [GRID_W*GRID_W-1:0]   Bomb_Map,
    output logic [GRID_W*GRID_W-1:0]   Flame_Map,
    output logic [GRID_W*GRID_W-1:0]   Tree_Clear,
    output logic                       Bomb_Grant_1,
    output logic                       Bomb_Grant_2,
    output logic [SLOTS-1:0]           Slot_Busy
);

    localparam int unsigned CELLS = GRID_W * GRID_W;
    localparam int unsigned IW    = $clog2(CELLS);
    localparam int unsigned SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CW    = $clog2(MAX_PER_PLAYER + 1);

    localparam logic [IW-1:0] GW         = IW'(GRID_W);
    localparam logic [IW-1:0] ONE        = IW'(1);
    localparam logic [31:0]   CELLS32    = 32'(CELLS);
    localparam logic [7:0]    FUSE_LAST  = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0]    FLAME_LAST = 8'(FLAME_FRAMES - 1);
    localparam logic [CW-1:0] MAX_C      = CW'(MAX_PER_PLAYER);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FUSE,
        S_FLAME
    } slot_state_t;

    slot_state_t     st_q    [SLOTS];
    slot_state_t     st_d    [SLOTS];
    logic [IW-1:0]   cell_q  [SLOTS];
    logic [IW-1:0]   cell_d  [SLOTS];
    logic            owner_q [SLOTS];
    logic            owner_d [SLOTS];
    logic [7:0]      timer_q [SLOTS];
    logic [7:0]      timer_d [SLOTS];
    logic [CW-1:0]   cnt_q   [2];
    logic [CW-1:0]   cnt_d   [2];
    logic [CW-1:0]   dec     [2];
    logic            prio_q;
    logic            prio_d;
    logic [1:0]      grant_d;
    logic [SLOTS-1:0] ignite;

    // placement scratch
    logic [SLOTS-1:0] avail;
    logic             claimed;
    logic [IW-1:0]    claim_cell;
    logic [31:0]      req;
    logic [IW-1:0]    idx;
    logic             p;
    logic             taken;
    logic             ok;
    logic             found;
    logic [SW-1:0]    pick;
    logic             both_req;

    logic [CELLS-1:0] bomb_d;
    logic [CELLS-1:0] flame_d;
    logic [CELLS-1:0] tree_d;

    // Centre plus in-row / in-column neighbours that are not walls.
    function automatic logic [CELLS-1:0] flame_mask(input logic [IW-1:0] c,
                                                    input logic [CELLS-1:0] walls);
        logic [CELLS-1:0] m;
        logic [IW-1:0]    row;
        logic [IW-1:0]    col;
        m   = '0;
        row = c / GW;
        col = c % GW;
        m[c] = 1'b1;
        if (col != '0 && !walls[c - ONE])
            m[c - ONE] = 1'b1;
        if (col != GW - ONE && !walls[c + ONE])
            m[c + ONE] = 1'b1;
        if (row != '0 && !walls[c - GW])
            m[c - GW] = 1'b1;
        if (row != GW - ONE && !walls[c + GW])
            m[c + GW] = 1'b1;
        return m;
    endfunction

    // Slot life cycle, request arbitration and owner bookkeeping.
    always_comb begin
        for (int unsigned s = 0; s < SLOTS; s++) begin
            st_d[s]    = st_q[s];
            cell_d[s]  = cell_q[s];
            owner_d[s] = owner_q[s];
            timer_d[s] = timer_q[s];
        end
        dec[0]     = '0;
        dec[1]     = '0;
        ignite     = '0;
        grant_d    = '0;
        avail      = '0;
        claimed    = 1'b0;
        claim_cell = '0;
        req        = '0;
        idx        = '0;
        p          = 1'b0;
        taken      = 1'b0;
        ok         = 1'b0;
        found      = 1'b0;
        pick       = '0;

        for (int unsigned s = 0; s < SLOTS; s++) begin
            case (st_q[s])
                S_FUSE: begin
                    if (timer_q[s] == FUSE_LAST || Flame_Map[cell_q[s]]) begin
                        st_d[s]    = S_FLAME;
                        timer_d[s] = '0;
                        ignite[s]  = 1'b1;
                    end else begin
                        timer_d[s] = timer_q[s] + 8'd1;
                    end
                end
                S_FLAME: begin
                    if (timer_q[s] == FLAME_LAST) begin
                        st_d[s]    = S_IDLE;
                        timer_d[s] = '0;
                        dec[owner_q[s]] = dec[owner_q[s]] + CNT_ONE;
                    end else begin
                        timer_d[s] = timer_q[s] + 8'd1;
                    end
                end
                default: avail[s] = 1'b1;
            endcase
        end

        // Priority player first; the second sees the first's claimed slot and cell.
        for (int unsigned t = 0; t < 2; t++) begin
            p     = (t == 0) ? prio_q : !prio_q;
            req   = p ? Bomb_Req_2 : Bomb_Req_1;
            idx   = req[IW-1:0];
            taken = claimed && (claim_cell == idx);
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (st_q[s] != S_IDLE && cell_q[s] == idx)
                    taken = 1'b1;
            end
            ok = (req != '0) && (req < CELLS32) && !Wall_Map[idx] && !taken &&
                 (cnt_q[p] < MAX_C) && (avail != '0);
            found = 1'b0;
            pick  = '0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (!found && avail[s]) begin
                    found = 1'b1;
                    pick  = SW'(s);
                end
            end
            if (ok) begin
                st_d[pick]    = S_FUSE;
                cell_d[pick]  = idx;
                owner_d[pick] = p;
                timer_d[pick] = '0;
                avail[pick]   = 1'b0;
                claimed       = 1'b1;
                claim_cell    = idx;
                grant_d[p]    = 1'b1;
            end
        end

        both_req = (Bomb_Req_1 != '0) && (Bomb_Req_2 != '0);
        prio_d   = prio_q ^ (both_req && (grant_d != '0));
        for (int unsigned q = 0; q < 2; q++)
            cnt_d[q] = cnt_q[q] + CW'(grant_d[q]) - dec[q];
    end

    // Map images built from next state so a grant shows on the map with the grant pulse.
    always_comb begin
        bomb_d  = '0;
        flame_d = '0;
        tree_d  = '0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (st_d[s] == S_FUSE)
                bomb_d[cell_d[s]] = 1'b1;
            if (st_d[s] == S_FLAME)
                flame_d = flame_d | flame_mask(cell_d[s], Wall_Map);
            if (ignite[s])
                tree_d = tree_d | (flame_mask(cell_q[s], Wall_Map) & Tree_Map);
        end
    end

    // Slot state, counters and registered outputs; synchronous reset clears all.
    always_ff @(posedge Frame_Clk) begin
        if (Reset) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                st_q[s]    <= S_IDLE;
                cell_q[s]  <= '0;
                owner_q[s] <= 1'b0;
                timer_q[s] <= '0;
            end
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            prio_q       <= 1'b0;
            Bomb_Map     <= '0;
            Flame_Map    <= '0;
            Tree_Clear   <= '0;
            Bomb_Grant_1 <= 1'b0;
            Bomb_Grant_2 <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                st_q[s]    <= st_d[s];
                cell_q[s]  <= cell_d[s];
                owner_q[s] <= owner_d[s];
                timer_q[s] <= timer_d[s];
            end
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            prio_q       <= prio_d;
            Bomb_Map     <= bomb_d;
            Flame_Map    <= flame_d;
            Tree_Clear   <= tree_d;
            Bomb_Grant_1 <= grant_d[0];
            Bomb_Grant_2 <= grant_d[1];
        end
    end

    // Busy flags follow the registered slot state.
    always_comb begin
        for (int unsigned s = 0; s < SLOTS; s++)
            Slot_Busy[s] = (st_q[s] != S_IDLE);
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Self-checking bench for bomb_scheduler: grant scoreboard, arbitration table
// and hand-written fuse/flame/chain/reset sequences.
module tb_bomb_scheduler;

    logic         Frame_Clk = 1'b0;
    logic         Reset;
    logic [31:0]  Bomb_Req_1;
    logic [31:0]  Bomb_Req_2;
    logic [143:0] Wall_Map;
    logic [143:0] Tree_Map;
    logic [143:0] Bomb_Map;
    logic [143:0] Flame_Map;
    logic [143:0] Tree_Clear;
    logic         Bomb_Grant_1;
    logic         Bomb_Grant_2;
    logic [3:0]   Slot_Busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string nm;
        logic  g1;
        logic  g2;
    } exp_t;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        g1;
        logic        g2;
        logic [3:0]  busy;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];

    bomb_scheduler #(
        .SLOTS(4),
        .MAX_PER_PLAYER(2),
        .FUSE_FRAMES(120),
        .FLAME_FRAMES(30),
        .GRID_W(12)
    ) dut (
        .Frame_Clk(Frame_Clk),
        .Reset(Reset),
        .Bomb_Req_1(Bomb_Req_1),
        .Bomb_Req_2(Bomb_Req_2),
        .Wall_Map(Wall_Map),
        .Tree_Map(Tree_Map),
        .Bomb_Map(Bomb_Map),
        .Flame_Map(Flame_Map),
        .Tree_Clear(Tree_Clear),
        .Bomb_Grant_1(Bomb_Grant_1),
        .Bomb_Grant_2(Bomb_Grant_2),
        .Slot_Busy(Slot_Busy)
    );

    always #5 Frame_Clk = ~Frame_Clk;

    function automatic logic [143:0] bits(input int a, input int b = -1, input int c = -1,
                                          input int d = -1, input int e = -1);
        logic [143:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        if (e >= 0) m[e] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one request cycle; expected grants go through the scoreboard.
    task automatic cyc(input string nm, input logic [31:0] r1, input logic [31:0] r2,
                       input logic g1, input logic g2);
        exp_t e;
        Bomb_Req_1 = r1;
        Bomb_Req_2 = r2;
        sb.push_back('{nm, g1, g2});
        @(posedge Frame_Clk);
        #1;
        e = sb.pop_front();
        chk({e.nm, " grant1"}, 144'(Bomb_Grant_1), 144'(e.g1));
        chk({e.nm, " grant2"}, 144'(Bomb_Grant_2), 144'(e.g2));
    endtask

    task automatic idle(input int n);
        Bomb_Req_1 = '0;
        Bomb_Req_2 = '0;
        repeat (n) @(posedge Frame_Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        Bomb_Req_1 = '0;
        Bomb_Req_2 = '0;
        repeat (2) @(posedge Frame_Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " bomb"},  Bomb_Map, '0);
        chk({nm, " flame"}, Flame_Map, '0);
        chk({nm, " tree"},  Tree_Clear, '0);
        chk({nm, " grants"}, 144'({Bomb_Grant_1, Bomb_Grant_2}), '0);
        chk({nm, " busy"},  144'(Slot_Busy), '0);
    endtask

    initial begin
        Wall_Map   = '0;
        Tree_Map   = '0;
        Bomb_Req_1 = '0;
        Bomb_Req_2 = '0;
        Reset      = 1'b1;
        repeat (2) @(posedge Frame_Clk);
        #1;
        chk_all_zero("reset");
        Reset = 1'b0;

        // Single bomb: fuse, flame, free
        cyc("t1 place26", 26, 0, 1, 0);
        chk("t1 bomb26", Bomb_Map, bits(26));
        chk("t1 busy", 144'(Slot_Busy), 144'(4'b0001));
        idle(119);
        chk("t1 fuse last bomb", Bomb_Map, bits(26));
        chk("t1 fuse last flame", Flame_Map, '0);
        idle(1);
        chk("t1 det bomb", Bomb_Map, '0);
        chk("t1 det flame", Flame_Map, bits(14, 25, 26, 27, 38));
        idle(29);
        chk("t1 flame last", Flame_Map, bits(14, 25, 26, 27, 38));
        idle(1);
        chk("t1 freed flame", Flame_Map, '0);
        chk("t1 freed busy", 144'(Slot_Busy), '0);

        // Arbitration table
        tbl[0] = '{32'd144, 32'd0,  1'b0, 1'b0, 4'b0000};
        tbl[1] = '{32'd50,  32'd50, 1'b1, 1'b0, 4'b0001};
        tbl[2] = '{32'd0,   32'd0,  1'b0, 1'b0, 4'b0001};
        tbl[3] = '{32'd51,  32'd51, 1'b0, 1'b1, 4'b0011};
        tbl[4] = '{32'd50,  32'd0,  1'b0, 1'b0, 4'b0011};
        tbl[5] = '{32'd60,  32'd61, 1'b1, 1'b1, 4'b1111};
        tbl[6] = '{32'd70,  32'd71, 1'b0, 1'b0, 4'b1111};
        tbl[7] = '{32'd143, 32'd0,  1'b0, 1'b0, 4'b1111};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("t2 row%0d", i), tbl[i].r1, tbl[i].r2, tbl[i].g1, tbl[i].g2);
            chk($sformatf("t2 row%0d busy", i), 144'(Slot_Busy), 144'(tbl[i].busy));
        end
        chk("t2 bombs", Bomb_Map, bits(50, 51, 60, 61));

        // Per-player limit and re-grant after free
        do_reset();
        cyc("t3 place13", 13, 0, 1, 0);
        cyc("t3 place15", 15, 0, 1, 0);
        cyc("t3 limit17", 17, 0, 0, 0);
        idle(147);
        cyc("t3 free edge17", 17, 0, 0, 0);
        chk("t3 free edge busy", 144'(Slot_Busy), 144'(4'b0010));
        cyc("t3 regrant17", 17, 0, 1, 0);
        chk("t3 regrant busy", 144'(Slot_Busy), 144'(4'b0001));
        chk("t3 regrant bomb", Bomb_Map, bits(17));

        // Edge column, wall and tree
        do_reset();
        Wall_Map[36] = 1'b1;
        Tree_Map[25] = 1'b1;
        cyc("t4 wall36", 36, 0, 0, 0);
        cyc("t4 place24", 24, 0, 1, 0);
        idle(119);
        chk("t4 pre flame", Flame_Map, '0);
        chk("t4 pre tree", Tree_Clear, '0);
        idle(1);
        chk("t4 flame", Flame_Map, bits(12, 24, 25));
        chk("t4 tree pulse", Tree_Clear, bits(25));
        idle(1);
        chk("t4 tree end", Tree_Clear, '0);
        chk("t4 flame hold", Flame_Map, bits(12, 24, 25));
        Wall_Map = '0;
        Tree_Map = '0;

        // Chain reaction
        do_reset();
        cyc("t5 placeA30", 30, 0, 1, 0);
        idle(49);
        cyc("t5 placeB31", 0, 31, 0, 1);
        idle(69);
        chk("t5 pre bomb", Bomb_Map, bits(30, 31));
        chk("t5 pre flame", Flame_Map, '0);
        idle(1);
        chk("t5 A flame bomb", Bomb_Map, bits(31));
        chk("t5 A flame", Flame_Map, bits(18, 29, 30, 31, 42));
        idle(1);
        chk("t5 chain bomb", Bomb_Map, '0);
        chk("t5 chain flame", Flame_Map, bits(18, 29, 30, 31, 42) | bits(19, 32, 43));
        chk("t5 chain busy", 144'(Slot_Busy), 144'(4'b0011));

        // Reset during flame with a held request
        Reset      = 1'b1;
        Bomb_Req_1 = '0;
        Bomb_Req_2 = 32'd40;
        @(posedge Frame_Clk);
        #1;
        chk_all_zero("t6 reset");
        Reset = 1'b0;
        cyc("t6 after reset", 0, 40, 0, 1);
        chk("t6 bomb40", Bomb_Map, bits(40));
        cyc("t6 held40", 0, 40, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
